// File: rtl/common.sv
// Shared scalar type aliases used across the core.
package common;

    typedef logic        u1;
    typedef logic [31:0] u32;
    typedef logic [63:0] u64;

endpackage

// File: rtl/pipes.sv
// Pipeline-stage types shared between the fetch unit and the IF/ID register.
package pipes;

    import common::*;

    // Fetch front-end states: issuing a request, holding a captured
    // instruction under back-pressure, or draining a stale request.
    typedef enum logic [1:0] {
        REQ     = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    localparam u64 PC_RESET_DEFAULT = 64'h8000_0000;

    // Payload handed to the IF/ID register each cycle.
    typedef struct packed {
        u1  valid;
        u64 pc;
        u32 raw_instr;
    } fetch_data_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, instruction-bus handshake,
// back-pressure buffering and redirect handling.
module fetch_unit
    import common::*;
    import pipes::*;
#(
    parameter u64 PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        jump_flag,
    input  logic [63:0] jump_pc,
    input  logic        load_stall,
    input  logic        dmem_busy,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_ok,
    input  logic [31:0] iresp_data,
    output fetch_data_t dataF_nxt,
    output logic        ifetch_busy
);

    fetch_state_t state, state_nxt;
    u64           pc, pc_nxt;
    u64           old_addr, old_addr_nxt;
    u32           instr_buf, instr_buf_nxt;

    u1            advance;
    u64           pc_inc;
    u64           jump_target;
    logic [1:0]   unused_jump_low;

    // Redirect targets are word aligned; the low two bits carry no meaning.
    assign jump_target     = {jump_pc[63:2], 2'b00};
    assign unused_jump_low = jump_pc[1:0];
    assign pc_inc          = pc + 64'd4;
    assign advance         = !load_stall && !dmem_busy;

    // Next-state, next-PC and output decode; redirect always beats advance.
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        old_addr_nxt  = old_addr;
        instr_buf_nxt = instr_buf;
        ireq_valid    = 1'b0;
        ireq_addr     = pc;
        dataF_nxt     = '0;
        ifetch_busy   = 1'b0;

        case (state)
            REQ: begin
                ireq_valid  = 1'b1;
                ireq_addr   = pc;
                dataF_nxt   = '{valid: iresp_ok, pc: pc, raw_instr: iresp_data};
                ifetch_busy = !iresp_ok;
                if (iresp_ok) begin
                    if (jump_flag) begin
                        pc_nxt = jump_target;
                    end else if (advance) begin
                        pc_nxt = pc_inc;
                    end else begin
                        instr_buf_nxt = iresp_data;
                        state_nxt     = HOLD;
                    end
                end else if (jump_flag) begin
                    old_addr_nxt = pc;
                    pc_nxt       = jump_target;
                    state_nxt    = DISCARD;
                end
            end
            HOLD: begin
                ireq_valid = 1'b0;
                dataF_nxt  = '{valid: 1'b1, pc: pc, raw_instr: instr_buf};
                if (jump_flag) begin
                    pc_nxt    = jump_target;
                    state_nxt = REQ;
                end else if (advance) begin
                    pc_nxt    = pc_inc;
                    state_nxt = REQ;
                end
            end
            DISCARD: begin
                ireq_valid  = 1'b1;
                ireq_addr   = old_addr;
                dataF_nxt   = '{valid: 1'b0, pc: old_addr, raw_instr: iresp_data};
                ifetch_busy = 1'b1;
                if (jump_flag) begin
                    pc_nxt = jump_target;
                end
                if (iresp_ok) begin
                    state_nxt = REQ;
                end
            end
            default: begin
                state_nxt = REQ;
            end
        endcase

        // A busy indication during a redirect would stall the IF/ID flush.
        if (jump_flag) begin
            ifetch_busy = 1'b0;
        end

        // While reset is held nothing leaves the unit.
        if (!reset) begin
            ireq_valid  = 1'b0;
            dataF_nxt   = '0;
            ifetch_busy = 1'b1;
        end
    end

    // State register; reset abandons any outstanding request without draining.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= REQ;
            pc        <= PC_RESET;
            old_addr  <= '0;
            instr_buf <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            old_addr  <= old_addr_nxt;
            instr_buf <= instr_buf_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a per-cycle vector table with a
// scoreboard of expected outputs, plus an asynchronous reset sequence.
module tb_fetch_unit;

    import common::*;
    import pipes::*;

    localparam logic [63:0] B = 64'h8000_0000;

    logic        clk;
    logic        reset;
    logic        jump_flag;
    logic [63:0] jump_pc;
    logic        load_stall;
    logic        dmem_busy;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_ok;
    logic [31:0] iresp_data;
    fetch_data_t dataF_nxt;
    logic        ifetch_busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    typedef struct {
        logic        pre_reset;
        logic        ls;
        logic        db;
        logic        jf;
        logic [63:0] jpc;
        logic        ok;
        logic [31:0] data;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_dv;
        logic        chk_dpc;
        logic [63:0] e_dpc;
        logic        chk_di;
        logic [31:0] e_di;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   idx_q[$];

    fetch_unit #(.PC_RESET(64'h8000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .jump_flag  (jump_flag),
        .jump_pc    (jump_pc),
        .load_stall (load_stall),
        .dmem_busy  (dmem_busy),
        .ireq_valid (ireq_valid),
        .ireq_addr  (ireq_addr),
        .iresp_ok   (iresp_ok),
        .iresp_data (iresp_data),
        .dataF_nxt  (dataF_nxt),
        .ifetch_busy(ifetch_busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required to have finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(
        input logic pre_reset, input logic ls, input logic db, input logic jf,
        input logic [63:0] jpc, input logic ok, input logic [31:0] data,
        input logic e_req, input logic [63:0] e_addr, input logic e_dv,
        input logic chk_dpc, input logic [63:0] e_dpc,
        input logic chk_di, input logic [31:0] e_di, input logic e_busy);
        vec_t v;
        v.pre_reset = pre_reset; v.ls = ls; v.db = db; v.jf = jf; v.jpc = jpc;
        v.ok = ok; v.data = data; v.e_req = e_req; v.e_addr = e_addr;
        v.e_dv = e_dv; v.chk_dpc = chk_dpc; v.e_dpc = e_dpc;
        v.chk_di = chk_di; v.e_di = e_di; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_forced(input string tag);
        check_val({tag, ".ireq_valid"}, 128'(ireq_valid), 128'd0);
        check_val({tag, ".dataF"}, 128'(dataF_nxt), 128'd0);
        check_val({tag, ".busy"}, 128'(ifetch_busy), 128'd1);
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        load_stall = v.ls;
        dmem_busy  = v.db;
        jump_flag  = v.jf;
        jump_pc    = v.jpc;
        iresp_ok   = v.ok;
        iresp_data = v.data;
        exp_q.push_back(v);
        idx_q.push_back(idx);
    endtask

    task automatic checkOutput();
        vec_t e;
        int   i;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e = exp_q.pop_front();
        i = idx_q.pop_front();
        check_val($sformatf("row%0d.ireq_valid", i), 128'(ireq_valid), 128'(e.e_req));
        if (e.e_req)
            check_val($sformatf("row%0d.ireq_addr", i), 128'(ireq_addr), 128'(e.e_addr));
        check_val($sformatf("row%0d.dv", i), 128'(dataF_nxt.valid), 128'(e.e_dv));
        if (e.chk_dpc)
            check_val($sformatf("row%0d.dpc", i), 128'(dataF_nxt.pc), 128'(e.e_dpc));
        if (e.chk_di)
            check_val($sformatf("row%0d.dinstr", i), 128'(dataF_nxt.raw_instr), 128'(e.e_di));
        check_val($sformatf("row%0d.busy", i), 128'(ifetch_busy), 128'(e.e_busy));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check_forced(tag);
        #1;
        reset = 1'b1;
    endtask

    // One table row = one clock cycle; outputs sampled on the falling edge.
    task automatic run_vec(input vec_t v, input int idx);
        @(posedge clk);
        #1;
        if (v.pre_reset) do_reset($sformatf("row%0d.reset", idx));
        applyStimulus(v, idx);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        reset      = 1'b0;
        jump_flag  = 1'b0;
        jump_pc    = '0;
        load_stall = 1'b0;
        dmem_busy  = 1'b0;
        iresp_ok   = 1'b0;
        iresp_data = '0;

        // rst ls db jf jpc ok data | req addr dv cdpc dpc cdi di busy
        // Streaming fetch, one response per cycle
        vecs.push_back(mk(1,0,0,0,0,1,32'h11, 1,B,1,1,B,1,32'h11,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h22, 1,B+4,1,1,B+4,1,32'h22,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h33, 1,B+8,1,1,B+8,1,32'h33,0));
        // Load stall captures into HOLD, then redirect during a slow request
        vecs.push_back(mk(1,1,0,0,0,1,32'h13, 1,B,1,1,B,1,32'h13,0));
        vecs.push_back(mk(0,1,0,0,0,0,32'h0,  0,0,1,1,B,1,32'h13,0));
        vecs.push_back(mk(0,1,0,0,0,0,32'h0,  0,0,1,1,B,1,32'h13,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,  0,0,1,1,B,1,32'h13,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,  1,B+4,0,1,B+4,1,32'h0,1));
        vecs.push_back(mk(0,0,0,1,B+64'h100,0,32'h0, 1,B+4,0,1,B+4,1,32'h0,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,  1,B+4,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,1,32'hDEAD_BEEF, 1,B+4,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,1,32'h44, 1,B+64'h100,1,1,B+64'h100,1,32'h44,0));
        // Two redirects while discarding: the later one wins
        vecs.push_back(mk(0,0,0,1,B+64'h100,0,32'h0, 1,B+64'h104,0,1,B+64'h104,1,32'h0,0));
        vecs.push_back(mk(0,0,0,1,B+64'h200,0,32'h0, 1,B+64'h104,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h55, 1,B+64'h104,0,0,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,0,1,32'h66, 1,B+64'h200,1,1,B+64'h200,1,32'h66,0));
        // Redirect with response in the same cycle, misaligned target
        vecs.push_back(mk(0,0,0,1,B+64'h103,1,32'h77, 1,B+64'h204,1,1,B+64'h204,1,32'h77,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,  1,B+64'h100,0,1,B+64'h100,1,32'h0,1));
        vecs.push_back(mk(0,0,0,0,0,1,32'h88, 1,B+64'h100,1,1,B+64'h100,1,32'h88,0));
        // Redirect in DISCARD together with the dropped response
        vecs.push_back(mk(0,0,0,1,B+64'h300,0,32'h0, 1,B+64'h104,0,1,B+64'h104,1,32'h0,0));
        vecs.push_back(mk(0,0,0,1,B+64'h400,1,32'h5, 1,B+64'h104,0,0,0,0,0,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'h99, 1,B+64'h400,1,1,B+64'h400,1,32'h99,0));
        // Data-side stall into HOLD, redirect out of HOLD
        vecs.push_back(mk(0,0,1,0,0,1,32'hAA, 1,B+64'h404,1,1,B+64'h404,1,32'hAA,0));
        vecs.push_back(mk(0,0,1,1,B+64'h500,0,32'h0, 0,0,1,1,B+64'h404,1,32'hAA,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'hBB, 1,B+64'h500,1,1,B+64'h500,1,32'hBB,0));
        // PC wraps modulo 2^64
        vecs.push_back(mk(0,0,0,1,64'hFFFF_FFFF_FFFF_FFFE,1,32'hCC, 1,B+64'h504,1,1,B+64'h504,1,32'hCC,0));
        vecs.push_back(mk(0,0,0,0,0,1,32'hDD, 1,64'hFFFF_FFFF_FFFF_FFFC,1,1,64'hFFFF_FFFF_FFFF_FFFC,1,32'hDD,0));
        vecs.push_back(mk(0,0,0,0,0,0,32'h0,  1,64'h0,0,1,64'h0,1,32'h0,1));

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // Asynchronous reset asserted in the middle of a HOLD cycle
        run_vec(mk(1,1,0,0,0,1,32'h13, 1,B,1,1,B,1,32'h13,0), 100);
        run_vec(mk(0,1,0,0,0,0,32'h0,  0,0,1,1,B,1,32'h13,0), 101);
        @(posedge clk);
        #3;
        check_val("hold.dv_before_reset", 128'(dataF_nxt.valid), 128'd1);
        reset = 1'b0;
        #1;
        check_forced("midhold.reset");
        @(posedge clk);
        #1;
        check_forced("midhold.reset_held");
        reset = 1'b1;
        run_vec(mk(0,0,0,0,0,0,32'h0,  1,B,0,1,B,1,32'h0,1), 102);
        run_vec(mk(0,0,0,0,0,1,32'h21, 1,B,1,1,B,1,32'h21,0), 103);
        run_vec(mk(0,0,0,0,0,1,32'h31, 1,B+4,1,1,B+4,1,32'h31,0), 104);

        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end. Generates the PC, runs the request/response handshake on the instruction bus, and delivers `fetch_data_t` on `dataF_nxt` into the IF/ID pipeline register. The unit also absorbs back-pressure and redirects. Its `ifetch_busy` output is ORed at top level into the IF/ID register's `handshake_stall`.

## Interface
Parameters:
- `PC_RESET`, default 64'h8000_0000: first fetch address after reset.

Ports (clock and reset first):
- `clk` in 1: the only clock.
- `reset` in 1: asynchronous, active-low (asserted at 0).
- `jump_flag` in 1: redirect request from the execute stage, single-cycle.
- `jump_pc` in 64: redirect target, valid when `jump_flag`=1.
- `load_stall` in 1: load-use stall.
- `dmem_busy` in 1: data-side handshake stall.
- `ireq_valid` out 1: instruction request valid.
- `ireq_addr` out 64: request address.
- `iresp_ok` in 1: one-cycle response strobe.
- `iresp_data` in 32: instruction word, valid with `iresp_ok`.
- `dataF_nxt` out `fetch_data_t`: `{valid, pc, raw_instr}` toward IF/ID.
- `ifetch_busy` out 1: no instruction deliverable this cycle.

## Operation
- Signal definitions:
  - `advance` = !`load_stall` && !`dmem_busy`.
  - `pc` register: next address to fetch.
  - `old_addr` register: address of an outstanding request that must be dropped.
  - `buf` register: 32-bit captured instruction.
- Bus rule: once `ireq_valid`=1, it stays high with `ireq_addr` stable until `iresp_ok`. An address is never withdrawn or changed mid-request.
- REQ:
  - `ireq_valid`=1, `ireq_addr`=`pc`.
  - `dataF_nxt` = {`iresp_ok`, `pc`, `iresp_data`}, combinational.
  - `iresp_ok` && `jump_flag`: `pc` ← `jump_pc`; stay in REQ; the response is dropped (the IF/ID register flushes).
  - `iresp_ok` && `advance`: `pc` ← `pc`+4; stay in REQ.
  - `iresp_ok` && !`advance`: `buf` ← `iresp_data`; go to HOLD.
  - !`iresp_ok` && `jump_flag`: `old_addr` ← `pc`, `pc` ← `jump_pc`; go to DISCARD.
- HOLD:
  - `ireq_valid`=0; `dataF_nxt` = {1, `pc`, `buf`}.
  - `jump_flag`: `pc` ← `jump_pc`; go to REQ.
  - Else `advance`: `pc` ← `pc`+4; go to REQ.
  - Else stay in HOLD.
- DISCARD:
  - `ireq_valid`=1, `ireq_addr`=`old_addr`; `dataF_nxt.valid`=0.
  - `jump_flag`: `pc` ← `jump_pc`, and the latest redirect wins.
  - `iresp_ok`: data dropped; go to REQ.
- Priority: `jump_flag` beats `advance`. Redirect during DISCARD with `iresp_ok` in the same cycle: go to REQ with the new `pc`.
- `ifetch_busy` = (REQ && !`iresp_ok`) || DISCARD, forced to 0 whenever `jump_flag`=1. Otherwise `handshake_stall` would block the IF/ID flush.
- `jump_pc[1:0]` is ignored; `pc[1:0]` is always 0. PC arithmetic is 64-bit modulo 2^64, so 64'hFFFF_FFFF_FFFF_FFFC+4 wraps to 0.

## Timing
- Reset (async assert, `reset`=0):
  - State REQ, `pc`=`PC_RESET`, `old_addr`=0, `buf`=0.
  - Outputs forced: `ireq_valid`=0, `dataF_nxt`='0, `ifetch_busy`=1.
- First `ireq_valid` appears in the first cycle after `reset` rises.
- Latency: the instruction appears on `dataF_nxt` in the same cycle as `iresp_ok` and is captured by IF/ID at the next edge. Back-to-back responses give one instruction per cycle.
- A redirect taken while a request is outstanding costs the remaining old response plus one full new request.
- `reset` asserted mid-request: state is abandoned with no drain. Bus IP is required to drop any outstanding response on reset.

## Structure
- `fetch_state_t` (REQ, HOLD, DISCARD), `PC_RESET` default, and `fetch_data_t` live in `pipes`. `u1`/`u32`/`u64` come from `common`.
- The unit is a single module with no sub-modules. Next-state/next-`pc` logic sits in one combinational block, with one `always_ff` on `posedge clk or negedge reset`.

## Test plan
- Reset then `iresp_ok` every cycle, `advance`=1 → `ireq_addr` 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; `dataF_nxt.valid`=1 each cycle.
- `iresp_ok` (data 32'h0000_0013) with `load_stall`=1 for 3 cycles → HOLD; `ireq_valid`=0; `dataF_nxt` = {1, 8000_0000, 0000_0013} stable; `ifetch_busy`=0; the next request after release is 8000_0004.
- `jump_flag` (`jump_pc`=8000_0100) while the request to 8000_0004 waits 2 more cycles → `ireq_addr` stays 8000_0004 until `iresp_ok`, that data is never valid, the next request is 8000_0100, and `ifetch_busy`=0 only in the jump cycle.
- Two redirects during DISCARD (8000_0100, then 8000_0200) → the next request after the drop is 8000_0200.
- `jump_flag` with `jump_pc`=8000_0103 in the `iresp_ok` cycle → the next request is 8000_0100, with no DISCARD.
- Async `reset` low mid-HOLD → `ireq_valid`=0 and `dataF_nxt`=0 immediately without a clock; restart at 8000_0000.
